// File: rtl/fir_tap_sequencer_if.sv
// Sample, coefficient-write and MAC-operand signal bundle for fir_tap_sequencer.
// The slave modport is the sequencer's view; the master modport is the feeder/consumer side.
interface fir_tap_sequencer_if #(
    parameter int TAPS   = 8,
    parameter int DATA_W = 16
);
    localparam int CW = $clog2(TAPS);

    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;

    logic              coef_we;
    logic [CW-1:0]     coef_addr;
    logic [DATA_W-1:0] coef_data;
    logic              coef_wr_err;

    logic              mac_clr;
    logic              mac_en;
    logic [DATA_W-1:0] mac_a;
    logic [DATA_W-1:0] mac_b;
    logic              mac_last;
    logic              done;

    modport master (
        output s_valid, s_data, coef_we, coef_addr, coef_data,
        input  s_ready, coef_wr_err, mac_clr, mac_en, mac_a, mac_b, mac_last, done
    );

    modport slave (
        input  s_valid, s_data, coef_we, coef_addr, coef_data,
        output s_ready, coef_wr_err, mac_clr, mac_en, mac_a, mac_b, mac_last, done
    );
endinterface

// File: rtl/fir_tap_sequencer.sv
// FIR operand sequencer: per accepted sample emits clear, TAPS (sample, coef) pairs, then done.
// Optional FIR_SEQ_HIST_CLR_EN adds a hist_clr input that wipes the sample history while idle.
module fir_tap_sequencer #(
    parameter int TAPS   = 8,
    parameter int DATA_W = 16
) (
    input  logic clk,
    input  logic reset,
`ifdef FIR_SEQ_HIST_CLR_EN
    input  logic hist_clr,
`endif
    fir_tap_sequencer_if.slave bus
);
    localparam int CW = $clog2(TAPS);
    localparam logic [CW-1:0] LAST_K = CW'(TAPS - 1);
    localparam logic [CW:0]   TAPS_X = (CW+1)'(TAPS);

    typedef enum logic [1:0] {IDLE, CLEAR, RUN, FLUSH} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     k_q, k_d;
    logic [CW-1:0]     wr_ptr_q;
    logic [CW-1:0]     newest_q;
    logic [DATA_W-1:0] hist_q [TAPS];
    logic [DATA_W-1:0] coef_q [TAPS];

    logic              accept;
    logic              hist_clr_i;
    logic              coef_ok;
    logic [CW:0]       idx_w;
    logic [CW-1:0]     rd_idx;

    logic              mac_clr_d, mac_en_d, mac_last_d, done_d;
    logic [DATA_W-1:0] mac_a_d, mac_b_d;
    logic              mac_clr_q, mac_en_q, mac_last_q, done_q, coef_wr_err_q;
    logic [DATA_W-1:0] mac_a_q, mac_b_q;

`ifdef FIR_SEQ_HIST_CLR_EN
    assign hist_clr_i = hist_clr & (state_q == IDLE);
`else
    assign hist_clr_i = 1'b0;
`endif

    // s_ready is gated by reset so it reads 0 for the whole time reset is held.
    assign bus.s_ready = reset & (state_q == IDLE) & ~hist_clr_i;
    assign accept      = bus.s_valid & bus.s_ready;
    assign coef_ok     = bus.coef_we & (state_q == IDLE) & (bus.coef_addr <= LAST_K);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        case (state_q)
            IDLE:  if (accept) state_d = CLEAR;
            CLEAR: begin
                state_d = RUN;
                k_d     = '0;
            end
            RUN: begin
                if (k_q == LAST_K) state_d = FLUSH;
                else               k_d     = k_q + 1'b1;
            end
            FLUSH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered, so they are decoded from the next state and next tap index.
    always_comb begin
        idx_w = {1'b0, newest_q} - {1'b0, k_d};
        if (k_d > newest_q) idx_w = idx_w + TAPS_X;
        rd_idx     = idx_w[CW-1:0];
        mac_clr_d  = (state_d == CLEAR);
        mac_en_d   = (state_d == RUN);
        mac_last_d = mac_en_d && (k_d == LAST_K);
        done_d     = (state_d == FLUSH);
        mac_a_d    = mac_en_d ? hist_q[rd_idx] : '0;
        mac_b_d    = mac_en_d ? coef_q[k_d] : '0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q      <= '0;
            newest_q      <= '0;
            hist_q        <= '{default: '0};
            coef_q        <= '{default: '0};
            mac_clr_q     <= 1'b0;
            mac_en_q      <= 1'b0;
            mac_last_q    <= 1'b0;
            done_q        <= 1'b0;
            mac_a_q       <= '0;
            mac_b_q       <= '0;
            coef_wr_err_q <= 1'b0;
        end else begin
            mac_clr_q     <= mac_clr_d;
            mac_en_q      <= mac_en_d;
            mac_last_q    <= mac_last_d;
            done_q        <= done_d;
            mac_a_q       <= mac_a_d;
            mac_b_q       <= mac_b_d;
            coef_wr_err_q <= bus.coef_we & (state_q != IDLE);
            if (coef_ok) coef_q[bus.coef_addr] <= bus.coef_data;
            if (hist_clr_i) begin
                hist_q   <= '{default: '0};
                wr_ptr_q <= '0;
            end else if (accept) begin
                hist_q[wr_ptr_q] <= bus.s_data;
                newest_q         <= wr_ptr_q;
                wr_ptr_q         <= (wr_ptr_q == LAST_K) ? '0 : wr_ptr_q + 1'b1;
            end
        end
    end

    assign bus.mac_clr     = mac_clr_q;
    assign bus.mac_en      = mac_en_q;
    assign bus.mac_last    = mac_last_q;
    assign bus.done        = done_q;
    assign bus.mac_a       = mac_a_q;
    assign bus.mac_b       = mac_b_q;
    assign bus.coef_wr_err = coef_wr_err_q;
endmodule
